// File: rtl/flash_spi_reader.sv
// Single-bit SPI NOR flash FAST READ engine returning big-endian 16-bit words, SCK = clk/2.
// Optional burst HOLD state (sequential words without re-addressing) enabled by FLASH_BURST_EN.
module flash_spi_reader #(
  parameter int unsigned STARTUP_CYCLES  = 1000,
  parameter int unsigned DUMMY_BITS      = 8,
  parameter int unsigned DESELECT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ready,
  input  logic        rd_req,
  input  logic [21:0] addr,
  output logic        busy,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [2:0] StInit  = 3'd0;
  localparam logic [2:0] StIdle  = 3'd1;
  localparam logic [2:0] StCmd   = 3'd2;
  localparam logic [2:0] StAddr  = 3'd3;
  localparam logic [2:0] StDummy = 3'd4;
  localparam logic [2:0] StData  = 3'd5;
  localparam logic [2:0] StDesel = 3'd6;
`ifdef FLASH_BURST_EN
  localparam logic [2:0] StHold  = 3'd7;
`endif

  localparam int unsigned TotalBits = 8 + 24 + DUMMY_BITS + 16;

  logic [2:0]  state;
  logic [31:0] cnt;
  logic [7:0]  bit_cnt;
  logic [7:0]  bit_nxt;
  logic        phase_b;
  logic [31:0] tx_sr;
  logic [31:0] tx_load;
  logic [15:0] rx_sr;
`ifdef FLASH_BURST_EN
  logic [21:0] addr_q;
`endif

  // 22-bit word address zero-extends to the 24-bit byte address, so its top bit is always 0.
  assign tx_load = {8'h0B, 1'b0, addr, 1'b0};
  assign bit_nxt = bit_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StInit;
      cnt        <= '0;
      bit_cnt    <= '0;
      phase_b    <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
`ifdef FLASH_BURST_EN
      addr_q     <= '0;
`endif
    end else begin
      dout_valid <= 1'b0;
      case (state)
        StInit: begin
          if (cnt == STARTUP_CYCLES - 1) begin
            ready <= 1'b1;
            cnt   <= '0;
            state <= StIdle;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StIdle: begin
          if (rd_req) begin
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= tx_load[31];
            tx_sr    <= {tx_load[30:0], 1'b0};
            bit_cnt  <= '0;
            phase_b  <= 1'b0;
            state    <= StCmd;
`ifdef FLASH_BURST_EN
            addr_q   <= addr;
`endif
          end
        end
        StCmd, StAddr, StDummy, StData: begin
          if (bit_cnt == 8'(TotalBits)) begin
            // Extra cycle after the last sample: publish the word and release the bus.
            dout       <= rx_sr;
            dout_valid <= 1'b1;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
            cnt        <= '0;
`ifdef FLASH_BURST_EN
            busy       <= 1'b0;
            state      <= StHold;
`else
            spi_cs_n   <= 1'b1;
            state      <= StDesel;
`endif
          end else if (!phase_b) begin
            spi_sck <= 1'b1;
            phase_b <= 1'b1;
          end else begin
            spi_sck <= 1'b0;
            phase_b <= 1'b0;
            bit_cnt <= bit_nxt;
            if (state == StData) rx_sr <= {rx_sr[14:0], spi_miso};
            if (bit_nxt != 8'(TotalBits)) begin
              spi_mosi <= tx_sr[31];
              tx_sr    <= {tx_sr[30:0], 1'b0};
            end
            if (bit_nxt == 8'(TotalBits - 16)) state <= StData;
            else if (bit_nxt == 8'd32)         state <= StDummy;
            else if (bit_nxt == 8'd8)          state <= StAddr;
          end
        end
        StDesel: begin
          if (cnt == DESELECT_CYCLES - 1) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
`ifdef FLASH_BURST_EN
        StHold: begin
          if (rd_req && (addr == addr_q + 22'd1)) begin
            addr_q  <= addr;
            busy    <= 1'b1;
            bit_cnt <= 8'(TotalBits - 16);
            phase_b <= 1'b0;
            state   <= StData;
          end else if (rd_req || (cnt == 32'd15)) begin
            // Non-sequential requests are dropped, not replayed.
            spi_cs_n <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= StDesel;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
`endif
        default: state <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_spi_reader.sv
// Scoreboard bench for flash_spi_reader with a behavioural SPI flash model.
// Accepted requests push expected words; a monitor pops them on dout_valid.
module tb_flash_spi_reader;
  localparam int Lat      = 113;
  localparam int BurstLat = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready, busy, dout_valid, spi_cs_n, spi_sck, spi_mosi;
  logic        rd_req = 1'b0;
  logic        spi_miso = 1'b0;
  logic [21:0] addr = '0;
  logic [15:0] dout;

  flash_spi_reader #(
    .STARTUP_CYCLES (1000),
    .DUMMY_BITS     (8),
    .DESELECT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ready     (ready),
    .rd_req    (rd_req),
    .addr      (addr),
    .busy      (busy),
    .dout      (dout),
    .dout_valid(dout_valid),
    .spi_cs_n  (spi_cs_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [21:0] wa);
    logic [31:0] t;
    if (wa == 22'h012345) return 16'hA55A;
    t = {10'd0, wa} * 32'h0000_9E37 + 32'h5A3C;
    return t[23:8];
  endfunction

  logic [15:0] exp_data[$];
  int          exp_due[$];
  logic [23:0] exp_addr[$];

  // Flash model: capture 8 cmd + 24 addr + 8 dummy bits, then stream words on SCK falls.
  int          bits = 0;
  int          sck_rises = 0;
  logic [39:0] hdr = '0;
  logic [23:0] fl_addr = '0;

  always @(negedge spi_cs_n) begin
    bits      = 0;
    sck_rises = 0;
    spi_miso  = 1'b0;
  end

  always @(posedge spi_sck) begin
    if (!spi_cs_n && !reset) begin
      if (bits < 40) hdr = {hdr[38:0], spi_mosi};
      bits++;
      sck_rises++;
      if (bits == 40) begin
        check("mosi_cmd", hdr[39:32], 8'h0B);
        check("mosi_dummy", hdr[7:0], 8'h00);
        fl_addr = hdr[31:8];
        if (exp_addr.size() == 0) check("mosi_addr_unexpected", 1, 0);
        else check("mosi_addr", fl_addr, exp_addr.pop_front());
      end
    end
  end

  always @(negedge spi_sck) begin
    int d;
    logic [15:0] w;
    if (!spi_cs_n && bits >= 40) begin
      d = bits - 40;
      w = mem_word(fl_addr[22:1] + 22'(d / 16));
      spi_miso = w[15 - (d % 16)];
    end
  end

  always @(posedge spi_cs_n) begin
    if (!reset && bits > 0) begin
`ifdef FLASH_BURST_EN
      check("sck_edges", (sck_rises >= 56) && ((sck_rises - 56) % 16 == 0), 1);
`else
      check("sck_edges", sck_rises, 56);
`endif
    end
  end

  // Monitor and acceptance reference model, sampled mid-cycle.
  int          sck_viol = 0, pulse_viol = 0, n_acc = 0, n_valid = 0, hi_cnt = 0;
  int          hold_left = 0;
  bit          prev_valid = 0, prev_cs = 1, had_txn = 0;
  logic [21:0] last_acc = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 0;
      prev_cs    = 1;
      had_txn    = 0;
      hold_left  = 0;
      hi_cnt     = 0;
    end else begin
      if (spi_cs_n && spi_sck) sck_viol++;
      if (spi_cs_n) hi_cnt++;
      else if (prev_cs) begin
        if (had_txn) check("cs_gap_min4", hi_cnt >= 4, 1);
        had_txn = 1;
        hi_cnt  = 0;
      end
      if (dout_valid) begin
        n_valid++;
        if (prev_valid) pulse_viol++;
        if (exp_data.size() == 0) check("spurious_valid", 1, 0);
        else begin
          check("dout", dout, exp_data.pop_front());
          check("latency", cyc, exp_due.pop_front());
        end
`ifdef FLASH_BURST_EN
        hold_left = 16;
`endif
      end
      if (rd_req && ready && !busy) begin
        if (hold_left > 0) begin
          if (addr == last_acc + 22'd1) begin
            exp_data.push_back(mem_word(addr));
            exp_due.push_back(cyc + 1 + BurstLat);
            last_acc = addr;
          end
          hold_left = 0;
        end else begin
          exp_data.push_back(mem_word(addr));
          exp_due.push_back(cyc + 1 + Lat);
          exp_addr.push_back({1'b0, addr, 1'b0});
          last_acc = addr;
          n_acc++;
        end
      end
      if (hold_left > 0) hold_left--;
      prev_valid = dout_valid;
      prev_cs    = spi_cs_n;
    end
  end

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy || !spi_cs_n || !ready || exp_data.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) check("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    int r, n;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("reset_values", {ready, busy, dout, dout_valid, spi_cs_n, spi_sck, spi_mosi},
             {1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    exp_data.delete();
    exp_due.delete();
    exp_addr.delete();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    r = cyc;
    n = 0;
    while (!ready && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check("ready_rise", cyc - r, 1000);
  endtask

  task automatic issue(input logic [21:0] a);
    wait_idle(400);
    @(posedge clk);
    #2 rd_req = 1'b1;
    addr = a;
    @(posedge clk);
    #2 rd_req = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    int n = 0;
    @(negedge clk);
    while (!dout_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) check("valid_timeout", 0, 1);
  endtask

  initial begin
    int acc0, v0;
    do_reset();

    issue(22'h012345);
    wait_idle(400);
    issue(22'h3FFFFF);
    wait_idle(400);

    // rd_req held high for 300 edges: accepts land every 113+5 cycles.
    acc0 = n_acc;
    @(posedge clk);
    #2 rd_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2 addr = 22'($urandom);
    end
    rd_req = 1'b0;
`ifndef FLASH_BURST_EN
    check("held_req_accepts", n_acc - acc0, 3);
`endif
    wait_idle(400);

    // Reset in the middle of ADDR (bit 10 of the address).
    issue(22'h2AAAAA);
    repeat (36) @(posedge clk);
    do_reset();
    issue(22'h0ABCDE);
    wait_idle(400);

`ifdef FLASH_BURST_EN
    issue(22'h000100);
    wait_valid(200);
    @(posedge clk);
    #2 rd_req = 1'b1;
    addr = 22'h000101;
    @(posedge clk);
    #2 rd_req = 1'b0;
    check("cs_low_between_words", spi_cs_n, 1'b0);
    wait_valid(60);
    v0 = n_valid;
    @(posedge clk);
    #2 rd_req = 1'b1;
    addr = 22'h000200;
    @(posedge clk);
    #2 rd_req = 1'b0;
    #1 check("nonseq_deselect", spi_cs_n, 1'b1);
    repeat (200) @(posedge clk);
    check("nonseq_dropped", n_valid - v0, 0);
`else
    v0 = n_valid;
    issue(22'h000100);
    wait_idle(400);
    check("single_valid", n_valid - v0, 1);
`endif

    // Random traffic, including requests while busy and sequential addresses.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #2 rd_req = ($urandom_range(0, 3) == 0);
      addr = $urandom_range(0, 1) ? last_acc + 22'd1 : 22'($urandom);
    end
    rd_req = 1'b0;
    wait_idle(400);

    check("queue_drained", exp_data.size(), 0);
    check("sck_low_when_deselected", sck_viol, 0);
    check("valid_one_cycle", pulse_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
